mult_unit: RTL and testbench

Iterative 32×32 multiplier that executes MULT/MULTU and holds the HI/LO result registers for the pipelined MIPS core. It sits beside the execute stage. It accepts the one-cycle start pulse the hazard unit already uses to begin its multiply stall. It completes well inside that unit's 63-cycle stall window. HI/LO are then readable by MFHI/MFLO and writable by MTHI/MTLO.

---
 rtl/mult_pkg.sv | 14 +
 rtl/mult_datapath.sv | 56 +++++
 rtl/mult_unit.sv | 108 ++++++++++
 tb/tb_mult_unit.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the iterative HI/LO multiplier.
// The hazard unit also reads MULT_LATENCY to size its multiply stall.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    SIGN = 2'd2
  } multState_t;

  localparam int MULT_STEPS   = 32;
  localparam int MULT_LATENCY = 33;

endpackage

// File: rtl/mult_datapath.sv
// Radix-2 shift-add datapath for mult_unit: operand magnitudes, the
// (WIDTH+1)-bit add/shift step and the final sign correction of the product.
module mult_datapath
  import mult_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product
);

  logic [WIDTH-1:0]   mcandReg;
  logic [WIDTH-1:0]   mplierReg;
  logic [2*WIDTH-1:0] accReg;
  logic               negReg;

  logic [WIDTH-1:0]   aMag;
  logic [WIDTH-1:0]   bMag;
  logic [WIDTH:0]     stepSum;

  // The most negative operand negates to itself, which is its correct
  // magnitude when read as unsigned.
  always_comb begin
    aMag    = (is_signed && a[WIDTH-1]) ? -a : a;
    bMag    = (is_signed && b[WIDTH-1]) ? -b : b;
    stepSum = {1'b0, accReg[2*WIDTH-1:WIDTH]}
            + {1'b0, (mplierReg[0] ? mcandReg : {WIDTH{1'b0}})};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcandReg  <= '0;
      mplierReg <= '0;
      accReg    <= '0;
      negReg    <= 1'b0;
    end else if (load) begin
      mcandReg  <= aMag;
      mplierReg <= bMag;
      accReg    <= '0;
      negReg    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
    end else if (step) begin
      // {carry, acc, mplier} >> 1; after WIDTH steps acc holds the product
      accReg    <= {stepSum, accReg[WIDTH-1:1]};
      mplierReg <= {accReg[0], mplierReg[WIDTH-1:1]};
    end
  end

  assign product = negReg ? -accReg : accReg;

endmodule

// File: rtl/mult_unit.sv
// MULT/MULTU unit with HI/LO registers: FSM, step counter and result
// registers, driving mult_datapath. Product appears 33 cycles after start.
module mult_unit
  import mult_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  multState_t         stateReg, stateNext;
  logic [CW-1:0]      countReg, countNext;
  logic               doneReg, doneNext;
  logic [WIDTH-1:0]   hiReg, loReg;

  logic               load;
  logic               step;
  logic               writeProduct;
  logic [2*WIDTH-1:0] product;

  mult_datapath #(.WIDTH(WIDTH)) datapath (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .step     (step),
    .is_signed(is_signed),
    .a        (a),
    .b        (b),
    .product  (product)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateReg <= IDLE;
      countReg <= '0;
      doneReg  <= 1'b0;
    end else begin
      stateReg <= stateNext;
      countReg <= countNext;
      doneReg  <= doneNext;
    end
  end

  // A start in any state wins: it aborts an operation in flight, including
  // one in SIGN, so the aborted product never reaches HI/LO.
  always_comb begin
    stateNext    = stateReg;
    countNext    = countReg;
    doneNext     = 1'b0;
    load         = 1'b0;
    step         = 1'b0;
    writeProduct = 1'b0;
    if (start) begin
      load      = 1'b1;
      countNext = '0;
      stateNext = BUSY;
    end else begin
      case (stateReg)
        IDLE: ;
        BUSY: begin
          step      = 1'b1;
          countNext = countReg + 1'b1;
          if (countReg == LAST_STEP) stateNext = SIGN;
        end
        SIGN: begin
          writeProduct = 1'b1;
          doneNext     = 1'b1;
          stateNext    = IDLE;
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  // The product has priority over a coincident MTHI/MTLO write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hiReg <= '0;
      loReg <= '0;
    end else begin
      if (writeProduct)  hiReg <= product[2*WIDTH-1:WIDTH];
      else if (hi_we)    hiReg <= wdata;
      if (writeProduct)  loReg <= product[WIDTH-1:0];
      else if (lo_we)    loReg <= wdata;
    end
  end

  assign busy = (stateReg != IDLE);
  assign done = doneReg;
  assign hi   = hiReg;
  assign lo   = loReg;

endmodule

// File: tb/tb_mult_unit.sv
// Self-checking bench for mult_unit: vector table, random operands against
// a plain-arithmetic product model, and hand-written multi-cycle sequences.
module tb_mult_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [31:0] a, b;
  logic        hi_we, lo_we;
  logic [31:0] wdata;
  logic        busy, done;
  logic [31:0] hi, lo;

  int passCount  = 0;
  int totalCount = 0;

  mult_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .is_signed(is_signed),
    .a        (a),
    .b        (b),
    .hi_we    (hi_we),
    .lo_we    (lo_we),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          sgn;
    logic [31:0] x;
    logic [31:0] y;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [63:0] refProd(bit sgn, logic [31:0] x, logic [31:0] y);
    longint p;
    if (sgn) begin
      p = longint'($signed(x)) * longint'($signed(y));
      return p;
    end
    return {32'd0, x} * {32'd0, y};
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    totalCount++;
    if (act === exp) passCount++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns cycles from the start edge to done observed; 0 if it never came.
  task automatic waitDone(output int lat);
    lat = 0;
    for (int n = 1; n <= 100; n++) begin
      tick();
      if (done === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic runOp(bit sgn, logic [31:0] x, logic [31:0] y, output int lat);
    is_signed = sgn;
    a         = x;
    b         = y;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    waitDone(lat);
    $display("op %s 0x%08h * 0x%08h -> hi=0x%08h lo=0x%08h latency=%0d",
             sgn ? "MULT " : "MULTU", x, y, hi, lo, lat);
  endtask

  initial begin
    int lat;
    bit sawDone;
    logic [63:0] expP;

    vecs[0] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
    vecs[1] = '{1'b1, 32'hFFFF_FFFD, 32'h0000_0007, 64'hFFFF_FFFF_FFFF_FFEB};
    vecs[2] = '{1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
    vecs[3] = '{1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000};
    vecs[4] = '{1'b0, 32'h8000_0000, 32'h0000_0002, 64'h0000_0001_0000_0000};
    vecs[5] = '{1'b1, 32'h0000_0001, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[6] = '{1'b0, 32'h0000_0001, 32'hFFFF_FFFF, 64'h0000_0000_FFFF_FFFF};
    vecs[7] = '{1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 64'h0000_0000_0000_0000};

    reset = 1'b0; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    tick(); tick();
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    reset = 1'b1;
    tick();

    // MT writes in IDLE
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hAAAA_5555;
    tick();
    hi_we = 1'b0; lo_we = 1'b0;
    check("mt_idle", {hi, lo}, 64'hAAAA_5555_AAAA_5555);

    // Reset asserted mid-BUSY clears everything at once
    is_signed = 1'b0; a = 32'd5; b = 32'd6; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("busy_before_reset", {63'd0, busy}, 64'd1);
    reset = 1'b0;
    #1;
    check("async_reset_busy", {63'd0, busy}, 64'd0);
    check("async_reset_done", {63'd0, done}, 64'd0);
    check("async_reset_hilo", {hi, lo}, 64'd0);
    #2 reset = 1'b1;
    sawDone = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done === 1'b1) sawDone = 1'b1;
    end
    check("no_done_after_reset", {63'd0, sawDone}, 64'd0);

    // Vector table
    for (int i = 0; i < 8; i++) begin
      runOp(vecs[i].sgn, vecs[i].x, vecs[i].y, lat);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'd33);
      check($sformatf("vec%0d_product", i), {hi, lo}, vecs[i].exp);
      tick();
      check($sformatf("vec%0d_done_pulse", i), {63'd0, done}, 64'd0);
    end

    // Random operands against the model
    for (int i = 0; i < 20; i++) begin
      bit sgn;
      logic [31:0] x, y;
      sgn = 1'($urandom_range(0, 1));
      x = $urandom;
      y = $urandom;
      if (i % 5 == 0) x = 32'h8000_0000;
      runOp(sgn, x, y, lat);
      check($sformatf("rand%0d_product", i), {hi, lo}, refProd(sgn, x, y));
    end

    // Abort: restart with new operands while busy, only one done
    is_signed = 1'b0; a = 32'd5; b = 32'd6; start = 1'b1;
    tick();
    start = 1'b0;
    sawDone = 1'b0;
    for (int i = 0; i < 11; i++) begin
      tick();
      if (done === 1'b1) sawDone = 1'b1;
    end
    runOp(1'b0, 32'd9, 32'd9, lat);
    check("abort_no_early_done", {63'd0, sawDone}, 64'd0);
    check("abort_latency", 64'(lat), 64'd33);
    check("abort_product", {hi, lo}, 64'd81);

    // MTHI during BUSY survives until SIGN; MTLO coincident with SIGN loses
    is_signed = 1'b0; a = 32'h0001_0000; b = 32'h0003_0000; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    hi_we = 1'b1; wdata = 32'h0000_1234;
    tick();
    hi_we = 1'b0;
    check("mthi_busy", {32'd0, hi}, 64'h1234);
    for (int i = 6; i < 32; i++) tick();
    check("mthi_held_to_sign", {32'd0, hi}, 64'h1234);
    check("busy_in_sign", {63'd0, busy}, 64'd1);
    lo_we = 1'b1; wdata = 32'h0000_DEAD;
    tick();
    lo_we = 1'b0;
    check("mt_vs_sign_done", {63'd0, done}, 64'd1);
    check("mt_vs_sign_product", {hi, lo}, 64'h0000_0003_0000_0000);
    $display("op MT/SIGN overlap -> hi=0x%08h lo=0x%08h", hi, lo);

    // Back-to-back: start in the done cycle
    runOp(1'b0, 32'd7, 32'd8, lat);
    check("b2b_first", {hi, lo}, 64'd56);
    check("b2b_in_done_cycle", {63'd0, done}, 64'd1);
    runOp(1'b0, 32'd2, 32'd3, lat);
    check("b2b_latency", 64'(lat), 64'd33);
    check("b2b_product", {hi, lo}, 64'd6);

    // start together with MTHI: both take effect
    is_signed = 1'b1; a = 32'hFFFF_FFFE; b = 32'd3; start = 1'b1;
    hi_we = 1'b1; wdata = 32'h0000_5555;
    tick();
    start = 1'b0; hi_we = 1'b0;
    check("start_mthi_hi", {32'd0, hi}, 64'h5555);
    check("start_mthi_busy", {63'd0, busy}, 64'd1);
    waitDone(lat);
    expP = refProd(1'b1, 32'hFFFF_FFFE, 32'd3);
    check("start_mthi_product", {hi, lo}, expP);
    $display("op MULT with MTHI -> hi=0x%08h lo=0x%08h latency=%0d", hi, lo, lat);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
